alu_op_sequencer: RTL

Multi-cycle controller that sequences the shared 32-bit ALU datapath. It accepts one operation at a time from decode over a valid/ready handshake, evaluates the ARM-style condition field against its architectural NZCV register, drives the ALU operands and command, and captures result and flags. It returns a write-back record over a second valid/ready handshake. The block sits between decode and the register-file write port and is the sole owner of the NZCV flags.

---
 rtl/alu_op_sequencer_if.sv | 44 ++++
 rtl/alu_op_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Decode-side op handshake, ALU datapath drive and write-back record of the ALU op sequencer.
// The sequencer uses the slave modport; decode/ALU/write-back side uses master.
interface alu_op_sequencer_if;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_cmd;
   logic [3:0]  op_cond;
   logic        op_s;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_rd;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_cmd;
   logic [31:0] alu_out;
   logic [3:0]  alu_flags;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [3:0]  res_rd;
   logic        res_we;
   logic        res_err;
   logic [3:0]  flags;

   modport slave (
      input  op_valid, op_cmd, op_cond, op_s, op_a, op_b, op_rd,
      output op_ready,
      output alu_a, alu_b, alu_cmd,
      input  alu_out, alu_flags,
      output res_valid, res_data, res_rd, res_we, res_err,
      input  res_ready,
      output flags
   );

   modport master (
      output op_valid, op_cmd, op_cond, op_s, op_a, op_b, op_rd,
      input  op_ready,
      input  alu_a, alu_b, alu_cmd,
      output alu_out, alu_flags,
      input  res_valid, res_data, res_rd, res_we, res_err,
      output res_ready,
      input  flags
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU op sequencer: accepts one op, evaluates its ARM condition against NZCV,
// runs one ALU cycle and returns a write-back record. Sole owner of the NZCV flags.
module alu_op_sequencer (
   input logic              clk,
   input logic              rst_n,
   alu_op_sequencer_if.slave bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned FW = 4;

   localparam logic [CW-1:0] CMD_AND = CW'(0);
   localparam logic [CW-1:0] CMD_XOR = CW'(1);
   localparam logic [CW-1:0] CMD_SUB = CW'(2);
   localparam logic [CW-1:0] CMD_RSB = CW'(3);
   localparam logic [CW-1:0] CMD_ADD = CW'(4);
   localparam logic [CW-1:0] CMD_CMP = CW'(10);
   localparam logic [CW-1:0] CMD_OR  = CW'(12);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state, state_nxt;
   logic [DW-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
   logic [CW-1:0]   cmd_q, cmd_d;
   logic [RW-1:0]   rd_q, rd_d;
   logic [FW-1:0]   flags_q, flags_d;
   logic            s_q, s_d, we_q, we_d, err_q, err_d;
   logic            ready_q, valid_q;

   function automatic logic legal_cmd(input logic [CW-1:0] c);
      return (c == CMD_AND) || (c == CMD_XOR) || (c == CMD_SUB) || (c == CMD_RSB) ||
             (c == CMD_ADD) || (c == CMD_CMP) || (c == CMD_OR);
   endfunction

   // Commands whose carry/overflow are meaningful; logic ops keep the old C,V.
   function automatic logic arith_cmd(input logic [CW-1:0] c);
      return (c == CMD_SUB) || (c == CMD_RSB) || (c == CMD_ADD) || (c == CMD_CMP);
   endfunction

   function automatic logic cond_pass(input logic [3:0] cond, input logic [FW-1:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return c;
         4'd3:    return !c;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return c && !z;
         4'd9:    return !c || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      a_d       = a_q;
      b_d       = b_q;
      cmd_d     = cmd_q;
      rd_d      = rd_q;
      s_d       = s_q;
      data_d    = data_q;
      we_d      = we_q;
      err_d     = err_q;
      flags_d   = flags_q;
      case (state)
         IDLE: begin
            if (bus.op_valid && ready_q) begin
               a_d   = bus.op_a;
               b_d   = bus.op_b;
               cmd_d = bus.op_cmd;
               rd_d  = bus.op_rd;
               s_d   = bus.op_s;
               err_d = 1'b0;
               // Illegal command takes priority over the condition check.
               if (!legal_cmd(bus.op_cmd)) begin
                  data_d    = '0;
                  we_d      = 1'b0;
                  err_d     = 1'b1;
                  state_nxt = RESP;
               end else if (!cond_pass(bus.op_cond, flags_q)) begin
                  data_d    = '0;
                  we_d      = 1'b0;
                  state_nxt = RESP;
               end else begin
                  state_nxt = EXEC;
               end
            end
         end
         EXEC: begin
            data_d = bus.alu_out;
            we_d   = (cmd_q != CMD_CMP);
            if (s_q || (cmd_q == CMD_CMP)) begin
               flags_d[3:2] = bus.alu_flags[3:2];
               if (arith_cmd(cmd_q)) flags_d[1:0] = bus.alu_flags[1:0];
            end
            state_nxt = RESP;
         end
         RESP: begin
            if (bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cmd_q   <= '0;
         rd_q    <= '0;
         s_q     <= 1'b0;
         data_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         flags_q <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         a_q     <= a_d;
         b_q     <= b_d;
         cmd_q   <= cmd_d;
         rd_q    <= rd_d;
         s_q     <= s_d;
         data_q  <= data_d;
         we_q    <= we_d;
         err_q   <= err_d;
         flags_q <= flags_d;
         ready_q <= (state_nxt == IDLE);
         valid_q <= (state_nxt == RESP);
      end
   end

   assign bus.op_ready  = ready_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_cmd   = cmd_q;
   assign bus.res_valid = valid_q;
   assign bus.res_data  = data_q;
   assign bus.res_rd    = rd_q;
   assign bus.res_we    = we_q;
   assign bus.res_err   = err_q;
   assign bus.flags     = flags_q;
endmodule
